relu_maxpool22: RTL and testbench



---
 rtl/relu_maxpool22.sv | 102 ++++++++++
 tb/tb_relu_maxpool22.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool22.sv
// relu_maxpool22: streaming ReLU + 2x2 max-pool + requantise.
// Consumes one signed accumulator per accepted cycle in raster order over a
// MAP_W x MAP_H map and emits the (MAP_W/2) x (MAP_H/2) pooled map. Horizontal
// pair maxima of even rows are parked in a half-row line buffer and combined
// with the matching pair of the following odd row.
module relu_maxpool22 #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 0,
  parameter int MAP_W     = 10,
  parameter int MAP_H     = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_last
);

  localparam int CW   = (MAP_W > 2) ? $clog2(MAP_W) : 1;
  localparam int RW   = (MAP_H > 2) ? $clog2(MAP_H) : 1;
  localparam int LB_N = MAP_W / 2;
  localparam int LW   = (LB_N > 2) ? $clog2(LB_N) : 1;
  // Largest positive value representable at the output width.
  localparam logic signed [IN_WIDTH-1:0] MAX_OUT =
    IN_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);

  logic [CW-1:0] col_reg, col_next;
  logic [RW-1:0] row_reg, row_next;
  logic signed [IN_WIDTH-1:0] pair_reg;
  logic signed [IN_WIDTH-1:0] lb_rd_reg;
  logic signed [IN_WIDTH-1:0] linebuf [LB_N];

  logic [LW-1:0] lb_idx;
  logic accept, col_odd, row_odd, col_end, row_end, emit;
  logic signed [IN_WIDTH-1:0] pmax, qmax, relu_val, shift_val;
  logic signed [OUT_WIDTH-1:0] sat_val;

  // Datapath: pair/quad maxima, ReLU, shift, saturation and counter advance.
  always_comb begin
    accept    = in_valid & ~clr;
    lb_idx    = LW'(col_reg >> 1);
    col_odd   = col_reg[0];
    row_odd   = row_reg[0];
    col_end   = (col_reg == CW'(MAP_W - 1));
    row_end   = (row_reg == RW'(MAP_H - 1));
    emit      = accept & col_odd & row_odd;
    pmax      = (in_data > pair_reg) ? in_data : pair_reg;
    qmax      = (pmax > lb_rd_reg) ? pmax : lb_rd_reg;
    relu_val  = qmax[IN_WIDTH-1] ? '0 : qmax;
    shift_val = relu_val >>> SHIFT;
    sat_val   = (shift_val > MAX_OUT) ? OUT_WIDTH'(MAX_OUT) : shift_val[OUT_WIDTH-1:0];
    col_next  = col_reg + CW'(1);
    row_next  = row_reg;
    if (col_end) begin
      col_next = '0;
      row_next = row_end ? '0 : row_reg + RW'(1);
    end
  end

  // Control state and registered outputs; clr restarts the frame but keeps out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg   <= '0;
      row_reg   <= '0;
      pair_reg  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      col_reg   <= '0;
      row_reg   <= '0;
      pair_reg  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= emit;
      out_last  <= emit & col_end & row_end;
      if (emit)
        out_data <= sat_val;
      if (accept) begin
        col_reg <= col_next;
        row_reg <= row_next;
        if (!col_odd)
          pair_reg <= in_data;
      end
    end
  end

  // Line buffer RAM: even rows store pair maxima; odd rows prefetch the entry
  // on the even column so the odd column sees it as a registered read.
  always_ff @(posedge clk) begin
    if (accept && !col_odd && row_odd)
      lb_rd_reg <= linebuf[lb_idx];
    if (accept && col_odd && !row_odd)
      linebuf[lb_idx] <= pmax;
  end

endmodule

// File: tb/tb_relu_maxpool22.sv
// Directed bench for relu_maxpool22: two instances (SHIFT=0 and SHIFT=4)
// share one input stream; outputs are checked every cycle against a map-level
// reference built from the inputs the bench itself accepted.
module tb_relu_maxpool22;

  logic clk, rst, clr, in_valid;
  logic signed [31:0] in_data;
  logic out_valid0, out_last0, out_valid4, out_last4;
  logic signed [7:0] out_data0, out_data4;

  int tests = 0;
  int fails = 0;
  int tb_col, tb_row;
  int exp_d0, exp_d4;
  int mapv [10][10];
  int got0 [$];
  int got4 [$];

  relu_maxpool22 #(.IN_WIDTH(32), .OUT_WIDTH(8), .SHIFT(0), .MAP_W(10), .MAP_H(10)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid0), .out_data(out_data0), .out_last(out_last0));

  relu_maxpool22 #(.IN_WIDTH(32), .OUT_WIDTH(8), .SHIFT(4), .MAP_W(10), .MAP_H(10)) dut4 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid4), .out_data(out_data4), .out_last(out_last4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference quad result: max of four, clamp negatives, shift, saturate to 127.
  function automatic int pool(input int a, input int b, input int c, input int d, input int sh);
    longint m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (m < 0) m = 0;
    m = m >>> sh;
    if (m > 127) m = 127;
    return int'(m);
  endfunction

  function automatic int at0(input int i);
    return (i < got0.size()) ? got0[i] : -1;
  endfunction

  function automatic int at4(input int i);
    return (i < got4.size()) ? got4[i] : -1;
  endfunction

  task automatic reset_model();
    tb_col = 0;
    tb_row = 0;
    got0.delete();
    got4.delete();
  endtask

  // One clock: drive inputs, let the edge pass, then check all outputs.
  task automatic step(input logic v, input logic c, input int d);
    logic ev, el;
    in_valid = v;
    clr      = c;
    in_data  = d;
    @(posedge clk);
    #1;
    ev = 1'b0;
    el = 1'b0;
    if (c) begin
      tb_col = 0;
      tb_row = 0;
    end else if (v) begin
      mapv[tb_row][tb_col] = d;
      if ((tb_row % 2 == 1) && (tb_col % 2 == 1)) begin
        ev = 1'b1;
        el = (tb_row == 9) && (tb_col == 9);
        exp_d0 = pool(mapv[tb_row-1][tb_col-1], mapv[tb_row-1][tb_col], mapv[tb_row][tb_col-1], d, 0);
        exp_d4 = pool(mapv[tb_row-1][tb_col-1], mapv[tb_row-1][tb_col], mapv[tb_row][tb_col-1], d, 4);
        got0.push_back(int'(out_data0));
        got4.push_back(int'(out_data4));
        $display("[TB] pooled r=%0d c=%0d dut0=%0d dut4=%0d last=%0d",
                 tb_row / 2, tb_col / 2, out_data0, out_data4, out_last0);
      end
      if (tb_col == 9) begin
        tb_col = 0;
        tb_row = (tb_row == 9) ? 0 : tb_row + 1;
      end else begin
        tb_col++;
      end
    end
    check("valid0", out_valid0, ev);
    check("valid4", out_valid4, ev);
    check("last0", out_last0, el);
    check("last4", out_last4, el);
    check("data0", out_data0, exp_d0);
    check("data4", out_data4, exp_d4);
  endtask

  task automatic ramp_map(input int offset);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        step(1'b1, 1'b0, offset + 10 * r + c);
  endtask

  task automatic check_ramp(input string tag);
    check({tag, "_count"}, got0.size(), 25);
    check({tag, "_first"}, at0(0), 11);
    check({tag, "_sixth"}, at0(5), 31);
    check({tag, "_last"}, at0(24), 99);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 0;
    exp_d0 = 0; exp_d4 = 0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid0", out_valid0, 0);
    check("rst_data0", out_data0, 0);
    check("rst_last0", out_last0, 0);
    check("rst_valid4", out_valid4, 0);
    check("rst_data4", out_data4, 0);
    check("rst_last4", out_last4, 0);
    rst = 1'b0;

    // Ramp map, continuous valid.
    ramp_map(0);
    check_ramp("ramp");

    // All negative: every pooled value clamps to zero.
    reset_model();
    for (int k = 0; k < 100; k++) step(1'b1, 1'b0, -5000);
    check("neg_count", got0.size(), 25);
    check("neg_last", at0(24), 0);
    check("neg_first4", at4(0), 0);

    // Two non-trivial quads, zeros elsewhere.
    reset_model();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        int d;
        d = 0;
        if (r == 0 && c == 0) d = 5000;
        if ((r == 0 && c == 1) || (r == 1 && c == 0) || (r == 1 && c == 1)) d = -1;
        if (r == 4 && c == 6) d = 100;
        if (r == 4 && c == 7) d = 50;
        if (r == 5 && c == 7) d = -7;
        step(1'b1, 1'b0, d);
      end
    check("quad_sat4", at4(0), 127);
    check("quad_mid4", at4(13), 6);
    check("quad_zero4", at4(1), 0);
    check("quad_sat0", at0(0), 127);
    check("quad_mid0", at0(13), 100);

    // Ramp with idle gaps.
    reset_model();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        int g;
        g = 0;
        while ($urandom_range(0, 99) < 40 && g < 8) begin
          step(1'b0, 1'b0, int'($urandom));
          g++;
        end
        step(1'b1, 1'b0, 10 * r + c);
      end
    check_ramp("gap");

    // Two maps back to back, second offset +100.
    reset_model();
    ramp_map(0);
    ramp_map(100);
    check("b2b_count", got0.size(), 50);
    check("b2b_end1", at0(24), 99);
    check("b2b_start2", at0(25), 111);
    check("b2b_sat2", at0(49), 127);
    check("b2b_shift4", at4(49), 12);

    // clr after 37 accepted inputs (clr beats a simultaneous valid).
    reset_model();
    for (int k = 0; k < 37; k++) step(1'b1, 1'b0, 10 * (k / 10) + (k % 10));
    step(1'b1, 1'b1, 12345);
    check("clr_hold0", out_data0, 35);
    reset_model();
    ramp_map(0);
    check_ramp("clr");

    // Asynchronous reset mid-cycle after 37 accepted inputs.
    reset_model();
    for (int k = 0; k < 37; k++) step(1'b1, 1'b0, 10 * (k / 10) + (k % 10));
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_data0", out_data0, 0);
    check("arst_data4", out_data4, 0);
    check("arst_valid0", out_valid0, 0);
    #2 rst = 1'b0;
    exp_d0 = 0;
    exp_d4 = 0;
    reset_model();
    ramp_map(0);
    check_ramp("arst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
